// File: rtl/acc_cpu_mc_if.sv
// Instruction and data memory bus of the accumulator core.
// master = core side, slave = memory side.
interface acc_cpu_mc_if #(
  parameter int DATA_W  = 8,
  parameter int IADDR_W = 4,
  parameter int DADDR_W = 4
);
  localparam int INST_W = 4 + DADDR_W;

  logic [IADDR_W-1:0] imem_addr;
  logic               imem_rd;
  logic [INST_W-1:0]  imem_data;
  logic               imem_ack;
  logic [DADDR_W-1:0] dmem_addr;
  logic               dmem_rd;
  logic               dmem_wr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_addr, imem_rd, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
    input  imem_data, imem_ack, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, imem_rd, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
    output imem_data, imem_ack, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU with separate instruction/data buses.
// Optional shifter (SHL/SHR) enabled by defining ACC_CPU_MC_SHIFT_EN.
//
// state | meaning
// FETCH | request instruction at PC, latch IR and advance PC on ack
// EXEC  | decode; register/jump ops complete, memory ops move on
// MEM   | hold data read/write until ack, then commit ACC/flags
// HALT  | no requests, everything frozen until reset
module acc_cpu_mc #(
  parameter int DATA_W  = 8,
  parameter int IADDR_W = 4,
  parameter int DADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  acc_cpu_mc_if.master      bus,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        opcode,
  output logic              halted,
  output logic              flag_z,
  output logic              flag_c
);
  localparam int INST_W = 4 + DADDR_W;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] MEM   = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_LDI = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hD;
  localparam logic [3:0] OP_SHR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [IADDR_W-1:0] PC_ONE = IADDR_W'(1);

  logic [1:0]         state;
  logic [IADDR_W-1:0] pcReg;
  logic [INST_W-1:0]  irReg;
  logic [DATA_W-1:0]  accReg;
  logic               zReg;
  logic               cReg;
  logic               started;

  logic [3:0]         op;
  logic [DADDR_W-1:0] operand;
  logic [DATA_W-1:0]  immExt;
  logic [IADDR_W-1:0] jmpTarget;
  logic [DATA_W-1:0]  aluRes;
  logic               aluCarry;
  logic               aluZero;
  logic               isMemOp;
  logic               isSta;
  logic               execWritesAcc;
  logic               execWritesC;
  logic               memWritesC;
  logic               takeJump;
  logic               imemRd;

  assign op      = irReg[INST_W-1:DADDR_W];
  assign operand = irReg[DADDR_W-1:0];

  generate
    if (DADDR_W >= DATA_W) begin : gImmTrunc
      assign immExt = operand[DATA_W-1:0];
    end else begin : gImmExt
      assign immExt = {{(DATA_W-DADDR_W){1'b0}}, operand};
    end
    if (DADDR_W >= IADDR_W) begin : gJmpTrunc
      assign jmpTarget = operand[IADDR_W-1:0];
    end else begin : gJmpExt
      assign jmpTarget = {{(IADDR_W-DADDR_W){1'b0}}, operand};
    end
  endgenerate

  // ALU result for the current IR; memory ops see dmem_rdata as operand.
  always_comb begin
    aluRes   = accReg;
    aluCarry = cReg;
    case (op)
      OP_LDA: aluRes = bus.dmem_rdata;
      OP_ADD: {aluCarry, aluRes} = {1'b0, accReg} + {1'b0, bus.dmem_rdata};
      OP_SUB: begin
        aluRes   = accReg - bus.dmem_rdata;
        aluCarry = (accReg < bus.dmem_rdata);
      end
      OP_AND: aluRes = accReg & bus.dmem_rdata;
      OP_OR:  aluRes = accReg | bus.dmem_rdata;
      OP_XOR: aluRes = accReg ^ bus.dmem_rdata;
      OP_NOT: aluRes = ~accReg;
      OP_LDI: aluRes = immExt;
`ifdef ACC_CPU_MC_SHIFT_EN
      OP_SHL: begin
        aluRes   = {accReg[DATA_W-2:0], 1'b0};
        aluCarry = accReg[DATA_W-1];
      end
      OP_SHR: begin
        aluRes   = {1'b0, accReg[DATA_W-1:1]};
        aluCarry = accReg[0];
      end
`endif
      default: aluRes = accReg;
    endcase
  end

  assign aluZero = (aluRes == '0);

  assign isSta   = (op == OP_STA);
  assign isMemOp = (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
                   (op == OP_XOR);
  assign memWritesC = (op == OP_ADD) || (op == OP_SUB);

`ifdef ACC_CPU_MC_SHIFT_EN
  assign execWritesAcc = (op == OP_NOT) || (op == OP_LDI) ||
                         (op == OP_SHL) || (op == OP_SHR);
  assign execWritesC   = (op == OP_SHL) || (op == OP_SHR);
`else
  assign execWritesAcc = (op == OP_NOT) || (op == OP_LDI);
  assign execWritesC   = 1'b0;
`endif

  assign takeJump = (op == OP_JMP) || ((op == OP_JZ) && zReg) ||
                    ((op == OP_JC) && cReg);

  // started keeps imem_rd low until the first clock edge after reset release.
  assign imemRd = started && (state == FETCH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pcReg   <= '0;
      irReg   <= '0;
      accReg  <= '0;
      zReg    <= 1'b0;
      cReg    <= 1'b0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        FETCH: begin
          if (imemRd && bus.imem_ack) begin
            irReg <= bus.imem_data;
            pcReg <= pcReg + PC_ONE;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (isMemOp) begin
            state <= MEM;
          end else if (op == OP_HLT) begin
            state <= HALT;
          end else begin
            state <= FETCH;
            if (execWritesAcc) begin
              accReg <= aluRes;
              zReg   <= aluZero;
            end
            if (execWritesC) cReg <= aluCarry;
            if (takeJump) pcReg <= jmpTarget;
          end
        end
        MEM: begin
          if (bus.dmem_ack) begin
            if (!isSta) begin
              accReg <= aluRes;
              zReg   <= aluZero;
            end
            if (memWritesC) cReg <= aluCarry;
            state <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  assign bus.imem_addr  = pcReg;
  assign bus.imem_rd    = imemRd;
  assign bus.dmem_addr  = operand;
  assign bus.dmem_rd    = (state == MEM) && !isSta;
  assign bus.dmem_wr    = (state == MEM) && isSta;
  assign bus.dmem_wdata = accReg;

  assign acc_out = accReg;
  assign alu_out = aluRes;
  assign opcode  = op;
  assign halted  = (state == HALT);
  assign flag_z  = zReg;
  assign flag_c  = cReg;
endmodule

// File: doc/acc_cpu_mc.md
ACC_CPU_MC -- requirements
Module: acc_cpu_mc

Interface
REQ-001 Parameter DATA_W, default 8, sets accumulator, ALU and data-bus width (minimum 4).
REQ-002 Parameter IADDR_W, default 4, sets program-counter and instruction-address width.
REQ-003 Parameter DADDR_W, default 4, sets operand-field and data-address width; instruction width INST_W = 4 + DADDR_W.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  IADDR_W  instruction address, equal to PC.
REQ-007 imem_rd  out  1  instruction read request.
REQ-008 imem_data  in  INST_W  instruction word: opcode in bits [INST_W-1:DADDR_W], operand in bits [DADDR_W-1:0].
REQ-009 imem_ack  in  1  instruction word valid this cycle.
REQ-010 dmem_addr  out  DADDR_W  data address, equal to the IR operand field.
REQ-011 dmem_rd / dmem_wr  out  1 each  data read and data write requests, never both high.
REQ-012 dmem_wdata  out  DATA_W  store data, equal to ACC.
REQ-013 dmem_rdata  in  DATA_W  load data.
REQ-014 dmem_ack  in  1  data transfer completes this cycle.
REQ-015 acc_out  out  DATA_W  accumulator; alu_out  out  DATA_W  combinational ALU result.
REQ-016 opcode  out  4  IR opcode; halted  out  1  core stopped; flag_z, flag_c  out  1 each.

Function
REQ-017 Opcodes are: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 JMP, A JZ, B JC, C LDI, D SHL, E SHR, F HLT.
REQ-018 The FSM has states FETCH, EXEC, MEM and HALT.
REQ-019 FETCH: imem_rd is high; on a cycle with imem_ack=1, IR takes imem_data, PC increments modulo 2^IADDR_W (wrapping to 0), and the state goes to EXEC.
REQ-020 EXEC: LDA, STA, ADD, SUB, AND, OR and XOR go to MEM; every other opcode completes in this cycle and goes to FETCH, except HLT, which goes to HALT.
REQ-021 MEM: dmem_rd (for LDA and the ALU ops) or dmem_wr (for STA) is held until dmem_ack; on the ack cycle ACC and flags update and the state goes to FETCH.
REQ-022 Minimum latency is 2 cycles for a register or jump instruction and 3 cycles for a memory instruction, with ack returned in the same cycle as the request.
REQ-023 ADD: {C, ACC} = ACC + mem, DATA_W+1 bits; SUB: ACC = ACC - mem modulo 2^DATA_W, with C=1 when borrow (ACC < mem).
REQ-024 AND, OR, XOR, NOT and LDA leave C unchanged; LDI loads the operand zero-extended (truncated when DADDR_W > DATA_W).
REQ-025 Z = (new ACC == 0) after every ACC-writing instruction; STA, NOP and jumps leave ACC, Z and C unchanged.
REQ-026 JMP loads PC with the operand's low IADDR_W bits, zero-extended; JZ/JC do so only when Z/C=1, otherwise PC keeps its already-incremented value.
REQ-027 HALT: no requests are issued, all state holds, and halted=1; only reset exits HALT.
REQ-028 An imem_ack or dmem_ack arriving while the matching request is low is ignored.
REQ-029 alu_out reflects the ALU result for the current IR and operand source in every state.

Reset
REQ-030 While reset=0: PC=0, IR=0, ACC=0, Z=0, C=0, state=FETCH, and imem_rd, dmem_rd, dmem_wr and halted are 0; outputs follow immediately, independent of clock.
REQ-031 Reset during MEM or FETCH aborts the transfer; requests drop asynchronously and no register commits.
REQ-032 After reset release, the first imem_rd assertion is from the first rising edge onward, with imem_addr=0.

Configuration
REQ-033 Macro ACC_CPU_MC_SHIFT_EN, when defined: SHL sets ACC=ACC<<1 with C=old ACC[DATA_W-1]; SHR sets ACC=ACC>>1 (logical) with C=old ACC[0]; Z updates for both.
REQ-034 Without ACC_CPU_MC_SHIFT_EN: opcodes D and E execute as NOP, leaving ACC and the flags unchanged, and the shifter logic is absent.

Verification
REQ-035 Defaults, ack tied high, program LDI 5; ADD [3] (mem[3]=0xFE); HLT -> ACC=0x03, C=1, Z=0, halted=1 after 2+3+2 cycles.
REQ-036 SUB with ACC=0x02, mem=0x03 -> ACC=0xFF, C=1; then SUB with mem=0xFF -> ACC=0x00, Z=1, C=0.
REQ-037 dmem_ack delayed 4 cycles on STA [7] -> dmem_wr high for exactly 5 cycles with dmem_wdata=ACC stable; mem[7] is written once.
REQ-038 PC at 15 executing NOP -> next imem_addr=0; JZ 9 with Z=0 falls through, with Z=1 loads imem_addr=9.
REQ-039 reset driven low mid-MEM with dmem_rd=1 -> dmem_rd=0 and acc_out=0 combinationally; restart fetches from address 0.
REQ-040 SHL on 0x81: with ACC_CPU_MC_SHIFT_EN -> ACC=0x02, C=1; without it -> ACC=0x81 and flags unchanged.
